l1_pmem_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data L1 caches, on their pmem_* side. Presents a single 128-bit line port to physical memory.
- Arbitrates between the two caches and latches the winner's request for the whole memory transaction.
- Routes the memory response back only to the granted cache.
- The I-cache port is read-only. The D-cache port supports line read and line write-back.

---
 rtl/l1_pmem_arbiter.sv | 106 ++++++++++
 tb/tb_l1_pmem_arbiter.sv | 601 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_pmem_arbiter.sv
// l1_pmem_arbiter: shares one physical-memory line port between the I and D L1 caches.
// The winner's request is latched for the whole transaction and the response returns only to it.
module l1_pmem_arbiter #(
    parameter int ROUND_ROBIN = 0,
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);
    // state  | meaning
    // IDLE   | no transaction; requests sampled on every edge
    // BUSY_I | I-cache line read in flight
    // BUSY_D | D-cache line read or write-back in flight
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              req_i, req_d, pick_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        req_i = i_pmem_read;
        req_d = d_pmem_read | d_pmem_write;
        // On contention round-robin hands the grant to whichever side lost last time.
        if (req_i && req_d) begin
            pick_d = (ROUND_ROBIN != 0) ? ~last_d_q : 1'b1;
        end else begin
            pick_d = req_d;
        end

        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    if (pick_d) begin
                        state_d  = BUSY_D;
                        last_d_d = 1'b1;
                        addr_d   = d_pmem_address;
                        wdata_d  = d_pmem_wdata;
                        wr_d     = d_pmem_write;
                    end else begin
                        state_d  = BUSY_I;
                        last_d_d = 1'b0;
                        addr_d   = i_pmem_address;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pmem_read    = (state_q == BUSY_I) || ((state_q == BUSY_D) && !wr_q);
    assign pmem_write   = (state_q == BUSY_D) && wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = pmem_resp && (state_q == BUSY_I);
    assign d_pmem_resp  = pmem_resp && (state_q == BUSY_D);
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Bench for l1_pmem_arbiter: two instances (fixed priority and round-robin), each with its own
// memory responder and transaction monitor, checked against a transaction-level reference.
module tb_l1_pmem_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        bit            unstable;
        int            start_cyc;
        int            resp_cyc;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_rd[2];
    logic [AW-1:0] i_addr[2];
    logic          i_resp[2];
    logic [LW-1:0] i_rdata[2];
    logic          d_rd[2];
    logic          d_wr[2];
    logic [AW-1:0] d_addr[2];
    logic [LW-1:0] d_wdata[2];
    logic          d_resp[2];
    logic [LW-1:0] d_rdata[2];
    logic          p_rd[2];
    logic          p_wr[2];
    logic [AW-1:0] p_addr[2];
    logic [LW-1:0] p_wdata[2];
    logic          p_resp[2];
    logic [LW-1:0] p_rdata[2];

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    txn_t          log0[$];
    txn_t          log1[$];
    int            i_pulses[2] = '{0, 0};
    int            d_pulses[2] = '{0, 0};
    int            lat_cfg[2] = '{3, 3};
    bit            rand_lat[2] = '{1'b0, 1'b0};
    bit            fixed_en[2] = '{1'b0, 1'b0};
    logic [LW-1:0] fixed_rdata[2] = '{'0, '0};
    int            inject_req[2] = '{0, 0};

    l1_pmem_arbiter #(.ROUND_ROBIN(0), .ADDR_W(AW), .LINE_W(LW)) dut0 (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_rd[0]), .i_pmem_address(i_addr[0]), .i_pmem_resp(i_resp[0]), .i_pmem_rdata(i_rdata[0]),
        .d_pmem_read(d_rd[0]), .d_pmem_write(d_wr[0]), .d_pmem_address(d_addr[0]), .d_pmem_wdata(d_wdata[0]),
        .d_pmem_resp(d_resp[0]), .d_pmem_rdata(d_rdata[0]),
        .pmem_read(p_rd[0]), .pmem_write(p_wr[0]), .pmem_address(p_addr[0]), .pmem_wdata(p_wdata[0]),
        .pmem_resp(p_resp[0]), .pmem_rdata(p_rdata[0])
    );

    l1_pmem_arbiter #(.ROUND_ROBIN(1), .ADDR_W(AW), .LINE_W(LW)) dut1 (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_rd[1]), .i_pmem_address(i_addr[1]), .i_pmem_resp(i_resp[1]), .i_pmem_rdata(i_rdata[1]),
        .d_pmem_read(d_rd[1]), .d_pmem_write(d_wr[1]), .d_pmem_address(d_addr[1]), .d_pmem_wdata(d_wdata[1]),
        .d_pmem_resp(d_resp[1]), .d_pmem_rdata(d_rdata[1]),
        .pmem_read(p_rd[1]), .pmem_write(p_wr[1]), .pmem_address(p_addr[1]), .pmem_wdata(p_wdata[1]),
        .pmem_resp(p_resp[1]), .pmem_rdata(p_rdata[1])
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        return {4{a, ~a}} ^ 128'h3C3C_1111_F0F0_2222_5A5A_3333_0F0F_4444;
    endfunction

    function automatic bit arb_pick_d(input bit want_i, input bit want_d, input bit rr, input bit last_was_d);
        if (want_i && want_d) return rr ? !last_was_d : 1'b1;
        return want_d;
    endfunction

    function automatic int log_size(input int k);
        if (k == 0) return log0.size();
        return log1.size();
    endfunction

    function automatic txn_t get_log(input int k, input int idx);
        if (k == 0) return log0[idx];
        return log1[idx];
    endfunction

    // Memory responder: answers a held read/write after a configurable number of cycles.
    task automatic mem_run(input int k);
        int cnt = 0;
        int cur_lat = 2;
        int inj_done = 0;
        p_resp[k] = 1'b0;
        p_rdata[k] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                p_resp[k] = 1'b0;
                p_rdata[k] = '0;
                cnt = 0;
                inj_done = inject_req[k];
            end else if (p_resp[k]) begin
                p_resp[k] = 1'b0;
                cnt = 0;
                cur_lat = $urandom_range(1, 4);
            end else if (inj_done != inject_req[k]) begin
                inj_done = inject_req[k];
                p_resp[k] = 1'b1;
            end else if (p_rd[k] || p_wr[k]) begin
                cnt++;
                if (cnt >= (rand_lat[k] ? cur_lat : lat_cfg[k])) begin
                    p_resp[k] = 1'b1;
                    p_rdata[k] = fixed_en[k] ? fixed_rdata[k] : mem_line(p_addr[k]);
                end
            end
        end
    endtask

    // Monitor: one record per completed transaction, including a flag if the request moved while busy.
    task automatic mon_run(input int k);
        txn_t cur;
        bit busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0;
                continue;
            end
            if (p_rd[k] || p_wr[k]) begin
                if (!busy) begin
                    busy = 1'b1;
                    cur.wr = p_wr[k];
                    cur.addr = p_addr[k];
                    cur.wdata = p_wdata[k];
                    cur.unstable = 1'b0;
                    cur.start_cyc = cyc;
                end
                if (p_wr[k] != cur.wr || p_addr[k] != cur.addr || p_wdata[k] != cur.wdata || (p_rd[k] && p_wr[k]))
                    cur.unstable = 1'b1;
            end
            if (i_resp[k]) i_pulses[k]++;
            if (d_resp[k]) d_pulses[k]++;
            if ((i_resp[k] || d_resp[k]) && busy) begin
                cur.is_d = d_resp[k];
                cur.rdata = d_resp[k] ? d_rdata[k] : i_rdata[k];
                cur.resp_cyc = cyc;
                if (i_resp[k] && d_resp[k]) cur.unstable = 1'b1;
                if (k == 0) log0.push_back(cur);
                else log1.push_back(cur);
                busy = 1'b0;
            end
        end
    endtask

    initial mem_run(0);
    initial mem_run(1);
    initial mon_run(0);
    initial mon_run(1);

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 1'b0;
            i_addr[k] = '0;
            d_rd[k] = 1'b0;
            d_wr[k] = 1'b0;
            d_addr[k] = '0;
            d_wdata[k] = '0;
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Raise one request, wait for its response pulse (bounded), drop it after the response edge.
    task automatic do_req(input int k, input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        bit ok = 1'b0;
        if (is_d) begin
            d_rd[k] = !wr;
            d_wr[k] = wr;
            d_addr[k] = a;
            d_wdata[k] = wd;
        end else begin
            i_rd[k] = 1'b1;
            i_addr[k] = a;
        end
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = is_d ? d_resp[k] : i_resp[k];
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL req_timeout dut%0d port=%s addr=%h got no resp want resp", k, is_d ? "D" : "I", a);
        end
        @(posedge clk);
        #1;
        if (is_d) begin
            d_rd[k] = 1'b0;
            d_wr[k] = 1'b0;
        end else begin
            i_rd[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            i_rd[k] = 1'b1;
            d_wr[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({p_rd[k], p_wr[k], i_resp[k], d_resp[k]} !== 4'b0000 || p_addr[k] !== '0 || p_wdata[k] !== '0
                || i_rdata[k] !== '0 || d_rdata[k] !== '0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d got rd=%b wr=%b ir=%b dr=%b addr=%h want all zero",
                         k, p_rd[k], p_wr[k], i_resp[k], d_resp[k], p_addr[k]);
            end
        end
        clear_inputs();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_i();
        int n0 = log_size(0);
        int ip = i_pulses[0];
        int dp = d_pulses[0];
        txn_t t;
        fixed_en[0] = 1'b1;
        fixed_rdata[0] = {16{8'hA5}};
        lat_cfg[0] = 3;
        fork
            do_req(0, 1'b0, 1'b0, 16'h1230, '0);
            begin
                #2;
                total++;
                if (p_rd[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL single_i.idle_read got=%b want=0", p_rd[0]);
                end
                @(posedge clk);
                #1;
                total++;
                if (p_rd[0] !== 1'b1 || p_wr[0] !== 1'b0 || p_addr[0] !== 16'h1230) begin
                    bad++;
                    $display("FAIL single_i.cycle1 got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=1230", p_rd[0], p_wr[0], p_addr[0]);
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        fixed_en[0] = 1'b0;
        total++;
        if (log_size(0) != n0 + 1) begin
            bad++;
            $display("FAIL single_i.count got=%0d want=%0d", log_size(0) - n0, 1);
        end else begin
            t = get_log(0, n0);
            total++;
            if (t.is_d !== 1'b0 || t.addr !== 16'h1230 || t.rdata !== {16{8'hA5}} || t.unstable) begin
                bad++;
                $display("FAIL single_i.txn got d=%b addr=%h rdata=%h unst=%b want d=0 addr=1230 rdata=a5..",
                         t.is_d, t.addr, t.rdata, t.unstable);
            end
        end
        total++;
        if (i_pulses[0] != ip + 1 || d_pulses[0] != dp) begin
            bad++;
            $display("FAIL single_i.pulses got i=%0d d=%0d want i=1 d=0", i_pulses[0] - ip, d_pulses[0] - dp);
        end
    endtask

    task automatic test_write_back();
        logic [LW-1:0] wd = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        int n0 = log_size(0);
        int ip = i_pulses[0];
        int dp = d_pulses[0];
        txn_t t;
        lat_cfg[0] = 3;
        fork
            do_req(0, 1'b1, 1'b1, 16'h4560, wd);
            begin
                @(posedge clk);
                #1;
                total++;
                if (p_rd[0] !== 1'b0 || p_wr[0] !== 1'b1 || p_addr[0] !== 16'h4560 || p_wdata[0] !== wd) begin
                    bad++;
                    $display("FAIL write_back.cycle1 got rd=%b wr=%b addr=%h wdata=%h want rd=0 wr=1 addr=4560 wdata=%h",
                             p_rd[0], p_wr[0], p_addr[0], p_wdata[0], wd);
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (log_size(0) != n0 + 1) begin
            bad++;
            $display("FAIL write_back.count got=%0d want=1", log_size(0) - n0);
        end else begin
            t = get_log(0, n0);
            total++;
            if (t.is_d !== 1'b1 || t.wr !== 1'b1 || t.addr !== 16'h4560 || t.wdata !== wd || t.unstable) begin
                bad++;
                $display("FAIL write_back.txn got d=%b wr=%b addr=%h wdata=%h unst=%b want d=1 wr=1 addr=4560 wdata=%h",
                         t.is_d, t.wr, t.addr, t.wdata, t.unstable, wd);
            end
        end
        total++;
        if (d_pulses[0] != dp + 1 || i_pulses[0] != ip) begin
            bad++;
            $display("FAIL write_back.pulses got d=%0d i=%0d want d=1 i=0", d_pulses[0] - dp, i_pulses[0] - ip);
        end
    endtask

    task automatic test_contention_fixed();
        int n0 = log_size(0);
        bit first_d = arb_pick_d(1'b1, 1'b1, 1'b0, 1'b0);
        txn_t a, b;
        fork
            do_req(0, 1'b0, 1'b0, 16'h1000, '0);
            do_req(0, 1'b1, 1'b0, 16'h2000, '0);
        join
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (log_size(0) != n0 + 2) begin
            bad++;
            $display("FAIL contention_fixed.count got=%0d want=2", log_size(0) - n0);
        end else begin
            a = get_log(0, n0);
            b = get_log(0, n0 + 1);
            total++;
            if (a.is_d !== first_d || a.addr !== (first_d ? 16'h2000 : 16'h1000) || a.rdata !== mem_line(a.addr)) begin
                bad++;
                $display("FAIL contention_fixed.first got d=%b addr=%h want d=%b", a.is_d, a.addr, first_d);
            end
            total++;
            if (b.is_d !== !first_d || b.addr !== (first_d ? 16'h1000 : 16'h2000) || b.rdata !== mem_line(b.addr)) begin
                bad++;
                $display("FAIL contention_fixed.second got d=%b addr=%h want d=%b", b.is_d, b.addr, !first_d);
            end
            total++;
            if (b.start_cyc - a.resp_cyc != 2) begin
                bad++;
                $display("FAIL contention_fixed.idle_gap got=%0d want=2", b.start_cyc - a.resp_cyc);
            end
        end
    endtask

    task automatic test_round_robin();
        int n0;
        int pend_i = 2;
        int pend_d = 2;
        bit last_d = 1'b0;
        bit exp_d;
        txn_t t;
        do_reset();
        n0 = log_size(1);
        lat_cfg[1] = 2;
        fork
            begin
                do_req(1, 1'b0, 1'b0, 16'hA100, '0);
                do_req(1, 1'b0, 1'b0, 16'hA200, '0);
            end
            begin
                do_req(1, 1'b1, 1'b0, 16'hB100, '0);
                do_req(1, 1'b1, 1'b1, 16'hB200, {4{32'hCAFE_F00D}});
            end
        join
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (log_size(1) != n0 + 4) begin
            bad++;
            $display("FAIL round_robin.count got=%0d want=4", log_size(1) - n0);
        end else begin
            for (int j = 0; j < 4; j++) begin
                exp_d = arb_pick_d(pend_i > 0, pend_d > 0, 1'b1, last_d);
                t = get_log(1, n0 + j);
                total++;
                if (t.is_d !== exp_d) begin
                    bad++;
                    $display("FAIL round_robin.order[%0d] got %s want %s", j, t.is_d ? "D" : "I", exp_d ? "D" : "I");
                end
                if (exp_d) pend_d--;
                else pend_i--;
                last_d = exp_d;
            end
        end
    endtask

    task automatic test_mid_change();
        int n0 = log_size(0);
        int dp = d_pulses[0];
        bit got = 1'b0;
        txn_t t;
        lat_cfg[0] = 4;
        d_rd[0] = 1'b1;
        d_addr[0] = 16'h3000;
        @(posedge clk);
        #1;
        d_addr[0] = 16'h3FF0;
        d_rd[0] = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = d_resp[0];
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (!got || d_pulses[0] != dp + 1 || log_size(0) != n0 + 1) begin
            bad++;
            $display("FAIL mid_change.resp got seen=%b pulses=%0d txns=%0d want 1 1 1", got, d_pulses[0] - dp, log_size(0) - n0);
        end else begin
            t = get_log(0, n0);
            total++;
            if (t.addr !== 16'h3000 || t.unstable || t.wr !== 1'b0) begin
                bad++;
                $display("FAIL mid_change.addr got=%h unst=%b want addr=3000 unst=0", t.addr, t.unstable);
            end
        end
        total++;
        if (p_rd[0] !== 1'b0 || p_wr[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_change.idle got rd=%b wr=%b want 0 0", p_rd[0], p_wr[0]);
        end
    endtask

    task automatic test_idle_resp();
        int n0 = log_size(0);
        inject_req[0]++;
        @(posedge clk);
        #2;
        total++;
        if (i_resp[0] !== 1'b0 || d_resp[0] !== 1'b0) begin
            bad++;
            $display("FAIL idle_resp.resp got i=%b d=%b (pmem_resp=%b) want 0 0", i_resp[0], d_resp[0], p_resp[0]);
        end
        @(posedge clk);
        #2;
        total++;
        if (p_rd[0] !== 1'b0 || p_wr[0] !== 1'b0 || log_size(0) != n0) begin
            bad++;
            $display("FAIL idle_resp.state got rd=%b wr=%b txns=%0d want 0 0 0", p_rd[0], p_wr[0], log_size(0) - n0);
        end
        #8;
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        int n0;
        txn_t t;
        lat_cfg[0] = 4;
        d_rd[0] = 1'b1;
        d_addr[0] = 16'h5000;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = d_resp[0];
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL reset_mid.busy got no resp want resp before reset");
        end
        #1 reset = 1'b1;
        d_rd[0] = 1'b0;
        #1;
        total++;
        if (p_rd[0] !== 1'b0 || p_wr[0] !== 1'b0 || d_resp[0] !== 1'b0 || i_resp[0] !== 1'b0 || p_addr[0] !== '0) begin
            bad++;
            $display("FAIL reset_mid.async got rd=%b wr=%b dr=%b ir=%b addr=%h want all zero",
                     p_rd[0], p_wr[0], d_resp[0], i_resp[0], p_addr[0]);
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        n0 = log_size(0);
        lat_cfg[0] = 2;
        do_req(0, 1'b0, 1'b0, 16'h6000, '0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (log_size(0) != n0 + 1) begin
            bad++;
            $display("FAIL reset_mid.after got txns=%0d want 1", log_size(0) - n0);
        end else begin
            t = get_log(0, n0);
            total++;
            if (t.is_d !== 1'b0 || t.addr !== 16'h6000 || t.rdata !== mem_line(16'h6000) || t.unstable) begin
                bad++;
                $display("FAIL reset_mid.txn got d=%b addr=%h want d=0 addr=6000", t.is_d, t.addr);
            end
        end
    endtask

    task automatic test_random(input int k);
        localparam int N = 6;
        logic [AW-1:0] pi_addr[N];
        bit            pd_wr[N];
        logic [AW-1:0] pd_addr[N];
        logic [LW-1:0] pd_wd[N];
        int            n0 = log_size(k);
        int            ii = 0;
        int            di = 0;
        txn_t          t;
        rand_lat[k] = 1'b1;
        for (int j = 0; j < N; j++) begin
            pi_addr[j] = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
            pd_addr[j] = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF0;
            pd_wr[j] = 1'($urandom_range(0, 1));
            pd_wd[j] = {$urandom, $urandom, $urandom, $urandom};
        end
        fork
            for (int j = 0; j < N; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                do_req(k, 1'b0, 1'b0, pi_addr[j], '0);
            end
            for (int j = 0; j < N; j++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                do_req(k, 1'b1, pd_wr[j], pd_addr[j], pd_wd[j]);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        rand_lat[k] = 1'b0;
        for (int idx = n0; idx < log_size(k); idx++) begin
            t = get_log(k, idx);
            total++;
            if (t.is_d && di < N) begin
                if (t.wr !== pd_wr[di] || t.addr !== pd_addr[di] || t.unstable
                    || (pd_wr[di] && t.wdata !== pd_wd[di]) || (!pd_wr[di] && t.rdata !== mem_line(pd_addr[di]))) begin
                    bad++;
                    $display("FAIL random%0d.d[%0d] got wr=%b addr=%h unst=%b want wr=%b addr=%h",
                             k, di, t.wr, t.addr, t.unstable, pd_wr[di], pd_addr[di]);
                end
                di++;
            end else if (!t.is_d && ii < N) begin
                if (t.wr !== 1'b0 || t.addr !== pi_addr[ii] || t.unstable || t.rdata !== mem_line(pi_addr[ii])) begin
                    bad++;
                    $display("FAIL random%0d.i[%0d] got addr=%h unst=%b want addr=%h", k, ii, t.addr, t.unstable, pi_addr[ii]);
                end
                ii++;
            end else begin
                bad++;
                $display("FAIL random%0d.extra got unexpected %s transaction addr=%h", k, t.is_d ? "D" : "I", t.addr);
            end
        end
        total++;
        if (ii != N || di != N) begin
            bad++;
            $display("FAIL random%0d.count got i=%0d d=%0d want i=%0d d=%0d", k, ii, di, N, N);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_i();
        test_write_back();
        test_contention_fixed();
        test_mid_change();
        test_idle_resp();
        test_round_robin();
        test_reset_mid();
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
